// File: rtl/ps2_scan_event_rx_pkg.sv
// Shared constants and decoder state encoding for the PS/2 scan-event receiver.
// Extends the scan code definitions used by the mini-games top level.
package ps2_scan_event_rx_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, 11-bit shifter
// with start/parity/stop checks, and an idle timeout that abandons partial frames.
module ps2_frame_rx
    import ps2_scan_event_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
    output logic       o_timeout
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [FW-1:0]          r_filt_cnt;
    logic                   r_clk_filt;
    logic                   r_clk_filt_d;
    logic [3:0]             r_bit_cnt;
    logic [9:0]             r_shift;
    logic [TW-1:0]          r_to_cnt;

    logic w_clk_s;
    logic w_dat_s;
    logic w_strobe;
    logic w_frame_ok;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];
    assign w_strobe = r_clk_filt_d & ~r_clk_filt;

    // r_shift[0] = start, [8:1] = data, [9] = parity; the stop bit is the live sample.
    assign w_frame_ok = ~r_shift[0] & w_dat_s & (^r_shift[9:1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync   <= '1;
            r_dat_sync   <= '1;
            r_filt_cnt   <= '0;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            o_byte_valid <= 1'b0;
            o_byte_data  <= '0;
            o_frame_err  <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
            r_clk_filt_d <= r_clk_filt;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_timeout    <= 1'b0;

            if (w_clk_s != r_clk_filt) begin
                if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                    r_clk_filt <= w_clk_s;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end

            if (w_strobe) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        o_byte_valid <= 1'b1;
                        o_byte_data  <= r_shift[8:1];
                    end else begin
                        o_frame_err  <= 1'b1;
                    end
                end else begin
                    r_shift   <= {w_dat_s, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (r_bit_cnt != '0) begin
                if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt   <= '0;
                    r_to_cnt    <= '0;
                    o_frame_err <= 1'b1;
                    o_timeout   <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_scan_event_rx.sv
// PS/2 keyboard receiver top: turns received bytes into make/break scan events,
// folding the 0xE0 (extended) and 0xF0 (break) prefixes into flags.
module ps2_scan_event_rx
    import ps2_scan_event_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_break,
    output logic       frame_err
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;
    logic       w_timeout;
    dec_state_t r_state;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .i_clk       (CLOCK_50),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk_in),
        .i_ps2_dat   (ps2_dat_in),
        .o_byte_valid(w_byte_valid),
        .o_byte_data (w_byte_data),
        .o_frame_err (w_frame_err),
        .o_timeout   (w_timeout)
    );

    assign frame_err = w_frame_err;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            event_valid <= 1'b0;
            event_code  <= '0;
            event_ext   <= 1'b0;
            event_break <= 1'b0;
        end else begin
            event_valid <= 1'b0;
            if (w_timeout) begin
                r_state <= ST_IDLE;
            end else if (w_byte_valid) begin
                if (is_prefix(w_byte_data)) begin
                    // Prefixes accumulate; repeated prefixes are absorbed.
                    case (r_state)
                        ST_IDLE:  r_state <= (w_byte_data == PS2_PREFIX_EXT) ? ST_EXT : ST_BRK;
                        ST_EXT:   r_state <= (w_byte_data == PS2_PREFIX_BRK) ? ST_EXT_BRK : ST_EXT;
                        ST_BRK:   r_state <= (w_byte_data == PS2_PREFIX_EXT) ? ST_EXT_BRK : ST_BRK;
                        default:  r_state <= ST_EXT_BRK;
                    endcase
                end else begin
                    event_valid <= 1'b1;
                    event_code  <= w_byte_data;
                    event_ext   <= (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
                    event_break <= (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
                    r_state     <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_event_rx.sv
// Directed bench for ps2_scan_event_rx: drives PS/2 frames with a scaled bit period
// and timeout, and checks event outputs and pulse counts after each step.
module tb_ps2_scan_event_rx;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 1000;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_dat_in = 1'b1;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int ev_cnt = 0;
    int er_cnt = 0;
    int ev0, er0;

    ps2_scan_event_rx #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .event_valid(event_valid),
        .event_code (event_code),
        .event_ext  (event_ext),
        .event_break(event_break),
        .frame_err  (frame_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (event_valid === 1'b1) ev_cnt <= ev_cnt + 1;
        if (frame_err === 1'b1)   er_cnt <= er_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits of a frame; glitch_bit >= 0 adds a 3-cycle low blip
    // on the PS/2 clock during that bit's high phase.
    task automatic send_frame(input logic [7:0] data, input bit flip_par,
                              input int nbits, input int glitch_bit);
        logic [10:0] fr;
        fr = {1'b1, (~^data) ^ flip_par, data, 1'b0};
        $display("frame data=%02h flip_par=%0d bits=%0d glitch_bit=%0d",
                 data, flip_par, nbits, glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_in = fr[i];
            if (i == glitch_bit) begin
                wait_cycles(8);
                ps2_clk_in = 1'b0;
                wait_cycles(3);
                ps2_clk_in = 1'b1;
                wait_cycles(HALF - 11);
            end else begin
                wait_cycles(HALF);
            end
            ps2_clk_in = 1'b0;
            wait_cycles(HALF);
            ps2_clk_in = 1'b1;
        end
        wait_cycles(HALF);
        ps2_dat_in = 1'b1;
        wait_cycles(30);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {31'd0, event_valid}, 32'd0);
        check({tag, "_code"},  {24'd0, event_code},  32'd0);
        check({tag, "_ext"},   {31'd0, event_ext},   32'd0);
        check({tag, "_brk"},   {31'd0, event_break}, 32'd0);
        check({tag, "_err"},   {31'd0, frame_err},   32'd0);
    endtask

    task automatic check_event(input string tag, input int n_ev, input int n_err,
                               input logic [7:0] code, input logic ext, input logic brk);
        check({tag, "_nev"},  ev_cnt - ev0, n_ev);
        check({tag, "_nerr"}, er_cnt - er0, n_err);
        check({tag, "_code"}, {24'd0, event_code}, {24'd0, code});
        check({tag, "_ext"},  {31'd0, event_ext},  {31'd0, ext});
        check({tag, "_brk"},  {31'd0, event_break}, {31'd0, brk});
    endtask

    task automatic snap();
        ev0 = ev_cnt;
        er0 = er_cnt;
    endtask

    initial begin
        wait_cycles(5);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_cycles(20);
        check_outputs_zero("post_reset");

        // Plain make code
        snap();
        send_frame(8'h1C, 1'b0, 11, -1);
        check_event("make_1c", 1, 0, 8'h1C, 1'b0, 1'b0);

        // Break prefix then code
        snap();
        send_frame(8'hF0, 1'b0, 11, -1);
        check("brk_prefix_nev", ev_cnt - ev0, 0);
        send_frame(8'h1C, 1'b0, 11, -1);
        check_event("break_1c", 1, 0, 8'h1C, 1'b0, 1'b1);

        // Extended break, then decoder must be back in IDLE
        snap();
        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'hF0, 1'b0, 11, -1);
        check("extbrk_prefix_nev", ev_cnt - ev0, 0);
        send_frame(8'h75, 1'b0, 11, -1);
        check_event("extbrk_75", 1, 0, 8'h75, 1'b1, 1'b1);
        snap();
        send_frame(8'h1C, 1'b0, 11, -1);
        check_event("idle_after_75", 1, 0, 8'h1C, 1'b0, 1'b0);

        // Parity error, then recovery
        snap();
        send_frame(8'h1C, 1'b1, 11, -1);
        check("parity_nerr", er_cnt - er0, 1);
        check("parity_nev", ev_cnt - ev0, 0);
        snap();
        send_frame(8'h1C, 1'b0, 11, -1);
        check_event("after_parity", 1, 0, 8'h1C, 1'b0, 1'b0);

        // Parity error leaves the extended prefix pending
        snap();
        send_frame(8'hE0, 1'b0, 11, -1);
        send_frame(8'h33, 1'b1, 11, -1);
        send_frame(8'h74, 1'b0, 11, -1);
        check_event("ext_kept", 1, 1, 8'h74, 1'b1, 1'b0);

        // Timeout on a partial frame clears the break prefix
        snap();
        send_frame(8'hF0, 1'b0, 11, -1);
        send_frame(8'h29, 1'b0, 5, -1);
        wait_cycles(TIMEOUT + 300);
        check("timeout_nerr", er_cnt - er0, 1);
        check("timeout_nev", ev_cnt - ev0, 0);
        snap();
        send_frame(8'h29, 1'b0, 11, -1);
        check_event("after_timeout", 1, 0, 8'h29, 1'b0, 1'b0);

        // Short clock glitch mid-frame is filtered out
        snap();
        send_frame(8'h5A, 1'b0, 11, 4);
        check_event("glitch_5a", 1, 0, 8'h5A, 1'b0, 1'b0);

        // Reset mid-frame
        snap();
        send_frame(8'h66, 1'b0, 4, -1);
        rst_n = 1'b0;
        wait_cycles(3);
        check_outputs_zero("midframe_reset");
        rst_n = 1'b1;
        wait_cycles(TIMEOUT + 100);
        snap();
        send_frame(8'h33, 1'b0, 11, -1);
        check_event("after_reset", 1, 0, 8'h33, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
